// File: rtl/airi5c_imm_gen_pipe_pkg.sv
// rtl/airi5c_imm_gen_pipe_pkg.sv - immediate format encodings and pipe state type
package airi5c_imm_gen_pipe_pkg;

   localparam int IMM_TYPE_WIDTH = 3;

   typedef enum logic [IMM_TYPE_WIDTH-1:0] {
      IMM_I  = 3'd0,
      IMM_S  = 3'd1,
      IMM_U  = 3'd2,
      IMM_J  = 3'd3,
      IMM_B  = 3'd4,
      IMM_Z  = 3'd5,
      IMM_SH = 3'd6
   } imm_type_e;

   // Occupancy of the output register O and the skid register K.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } pipe_state_e;

endpackage

// File: rtl/airi5c_imm_gen_pipe_if.sv
// rtl/airi5c_imm_gen_pipe_if.sv - valid/ready bundle between decode, immediate generator and operand mux
interface airi5c_imm_gen_pipe_if #(
   parameter int XLEN   = 32,
   parameter int TYPE_W = 3
) ();
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       inst;
   logic [XLEN-1:0]   pc;
   logic [TYPE_W-1:0] imm_type;
   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   imm;
   logic [XLEN-1:0]   target;
   logic              illegal;

   modport master (
      output in_valid, inst, pc, imm_type, out_ready,
      input  in_ready, out_valid, imm, target, illegal
   );

   modport slave (
      input  in_valid, inst, pc, imm_type, out_ready,
      output in_ready, out_valid, imm, target, illegal
   );
endinterface

// File: rtl/airi5c_imm_extract.sv
// rtl/airi5c_imm_extract.sv - combinational immediate extraction and sign/zero extension
module airi5c_imm_extract
   import airi5c_imm_gen_pipe_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int TYPE_W = IMM_TYPE_WIDTH
) (
   input  logic [31:0]       inst,
   input  logic [TYPE_W-1:0] imm_type,
   output logic [XLEN-1:0]   imm,
   output logic              illegal
);

   // The opcode field never contributes to any immediate.
   logic unused_opcode;
   assign unused_opcode = ^inst[6:0];

   logic [5:0] shamt;
   assign shamt = (XLEN == 64) ? inst[25:20] : {1'b0, inst[24:20]};

   always_comb begin
      imm     = '0;
      illegal = 1'b0;
      case (imm_type)
         TYPE_W'(IMM_I):  imm = XLEN'($signed(inst[31:20]));
         TYPE_W'(IMM_S):  imm = XLEN'($signed({inst[31:25], inst[11:7]}));
         TYPE_W'(IMM_U):  imm = XLEN'($signed({inst[31:12], 12'b0}));
         TYPE_W'(IMM_J):  imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
         TYPE_W'(IMM_B):  imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
         TYPE_W'(IMM_Z):  imm = XLEN'(inst[19:15]);
         TYPE_W'(IMM_SH): imm = XLEN'(shamt);
         default:         illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/airi5c_imm_gen_pipe.sv
// rtl/airi5c_imm_gen_pipe.sv - registered immediate/target generator with a 2-entry skid buffer
module airi5c_imm_gen_pipe
   import airi5c_imm_gen_pipe_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int TYPE_W = IMM_TYPE_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset,
   airi5c_imm_gen_pipe_if.slave   bus
);

   logic [XLEN-1:0] ext_imm;
   logic            ext_illegal;
   logic [XLEN-1:0] ext_target;

   airi5c_imm_extract #(
      .XLEN   (XLEN),
      .TYPE_W (TYPE_W)
   ) u_extract (
      .inst     (bus.inst),
      .imm_type (bus.imm_type),
      .imm      (ext_imm),
      .illegal  (ext_illegal)
   );

   // Illegal types extract imm=0, so the target naturally falls back to pc.
   assign ext_target = bus.pc + ext_imm;

   pipe_state_e     state;
   logic            in_ready_q;
   logic            out_valid_q;
   logic [XLEN-1:0] o_imm, o_target, k_imm, k_target;
   logic            o_illegal, k_illegal;

   logic in_fire, out_fire;
   assign in_fire  = bus.in_valid & in_ready_q;
   assign out_fire = out_valid_q & bus.out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         o_imm       <= '0;
         o_target    <= '0;
         o_illegal   <= 1'b0;
         k_imm       <= '0;
         k_target    <= '0;
         k_illegal   <= 1'b0;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (in_fire) begin
                  o_imm       <= ext_imm;
                  o_target    <= ext_target;
                  o_illegal   <= ext_illegal;
                  out_valid_q <= 1'b1;
                  state       <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  o_imm     <= ext_imm;
                  o_target  <= ext_target;
                  o_illegal <= ext_illegal;
               end else if (in_fire) begin
                  k_imm      <= ext_imm;
                  k_target   <= ext_target;
                  k_illegal  <= ext_illegal;
                  in_ready_q <= 1'b0;
                  state      <= ST_TWO;
               end else if (out_fire) begin
                  out_valid_q <= 1'b0;
                  state       <= ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (out_fire) begin
                  o_imm      <= k_imm;
                  o_target   <= k_target;
                  o_illegal  <= k_illegal;
                  k_imm      <= '0;
                  k_target   <= '0;
                  k_illegal  <= 1'b0;
                  in_ready_q <= 1'b1;
                  state      <= ST_ONE;
               end
            end
            default: begin
               state       <= ST_EMPTY;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.imm       = o_imm;
   assign bus.target    = o_target;
   assign bus.illegal   = o_illegal;

endmodule
